// File: rtl/alarm_beep_sequencer_if.sv
// Handshake bundle between the alarm sequencer and its neighbours.
//   alarm_trigger/snooze/dismiss : 1-cycle request pulses into the sequencer
//   alarm_active/tone_bus        : buzzer enable and tone word to the sound module
//   snoozing/busy/timed_out      : status back to the control logic
// master drives the requests (upstream logic / bench); slave is the sequencer.
interface alarm_beep_sequencer_if;
   logic        alarm_trigger;
   logic        snooze;
   logic        dismiss;
   logic        alarm_active;
   logic [23:0] tone_bus;
   logic        snoozing;
   logic        busy;
   logic        timed_out;

   modport master (
      output alarm_trigger, snooze, dismiss,
      input  alarm_active, tone_bus, snoozing, busy, timed_out
   );

   modport slave (
      input  alarm_trigger, snooze, dismiss,
      output alarm_active, tone_bus, snoozing, busy, timed_out
   );
endinterface

// File: rtl/alarm_beep_sequencer.sv
// Alarm buzzer sequencer. Produces beep/gap bursts separated by pauses, raises
// the tone one level per completed burst (saturating at level 3), handles
// snooze and dismiss, and gives up after MAX_BURSTS bursts.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of alarm_beep_sequencer_if (requests in, buzzer/status out)
// All outputs are registered: they reflect the state entered on the last edge.
module alarm_beep_sequencer #(
   parameter int unsigned BEEP_ON_CYC  = 50_000_000,
   parameter int unsigned BEEP_OFF_CYC = 25_000_000,
   parameter int unsigned BEEPS        = 4,
   parameter int unsigned PAUSE_CYC    = 100_000_000,
   parameter int unsigned MAX_BURSTS   = 60,
   parameter int unsigned SNOOZE_CYC   = 32'hFFFF_FFFF,
   parameter int unsigned MAX_SNOOZE   = 3,
   parameter logic [23:0] TONE0        = 24'h000001,
   parameter logic [23:0] TONE1        = 24'h000003,
   parameter logic [23:0] TONE2        = 24'h000007,
   parameter logic [23:0] TONE3        = 24'h00000F
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alarm_beep_sequencer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, BEEP_ON, BEEP_OFF, PAUSE, SNOOZE} state_t;

   state_t      state;
   logic [31:0] phase;
   logic [31:0] term;
   logic [31:0] beep_cnt;
   logic [31:0] burst_cnt;
   logic [31:0] snooze_cnt;
   logic [1:0]  level;

   logic        active_q;
   logic [23:0] tone_q;
   logic        snoozing_q;
   logic        busy_q;
   logic        timed_out_q;

   assign bus.alarm_active = active_q;
   assign bus.tone_bus     = tone_q;
   assign bus.snoozing     = snoozing_q;
   assign bus.busy         = busy_q;
   assign bus.timed_out    = timed_out_q;

   function automatic logic [23:0] tone_of(input logic [1:0] lvl);
      case (lvl)
         2'd0:    return TONE0;
         2'd1:    return TONE1;
         2'd2:    return TONE2;
         default: return TONE3;
      endcase
   endfunction

   // Last phase value of the current state; the state exits on the edge
   // where phase sits at this value, so a state lasts exactly <param> cycles.
   always_comb begin
      term = '0;
      case (state)
         BEEP_ON:  term = BEEP_ON_CYC - 1;
         BEEP_OFF: term = BEEP_OFF_CYC - 1;
         PAUSE:    term = PAUSE_CYC - 1;
         SNOOZE:   term = SNOOZE_CYC - 1;
         default:  term = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         phase       <= '0;
         beep_cnt    <= '0;
         burst_cnt   <= '0;
         snooze_cnt  <= '0;
         level       <= '0;
         active_q    <= 1'b0;
         tone_q      <= '0;
         snoozing_q  <= 1'b0;
         busy_q      <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         timed_out_q <= 1'b0;
         // Saturating phase count; every transition below reloads it to 0.
         if (phase != term) phase <= phase + 32'd1;

         case (state)
            IDLE: begin
               if (bus.alarm_trigger) begin
                  state      <= BEEP_ON;
                  phase      <= '0;
                  beep_cnt   <= '0;
                  burst_cnt  <= '0;
                  snooze_cnt <= '0;
                  level      <= '0;
                  active_q   <= 1'b1;
                  tone_q     <= TONE0;
                  snoozing_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end

            default: begin
               // alarm_trigger is deliberately not looked at while busy.
               if (bus.dismiss) begin
                  state      <= IDLE;
                  phase      <= '0;
                  beep_cnt   <= '0;
                  burst_cnt  <= '0;
                  snooze_cnt <= '0;
                  level      <= '0;
                  active_q   <= 1'b0;
                  tone_q     <= '0;
                  snoozing_q <= 1'b0;
                  busy_q     <= 1'b0;
               end else if (bus.snooze && state != SNOOZE && snooze_cnt < MAX_SNOOZE) begin
                  state      <= SNOOZE;
                  phase      <= '0;
                  snooze_cnt <= snooze_cnt + 32'd1;
                  active_q   <= 1'b0;
                  tone_q     <= '0;
                  snoozing_q <= 1'b1;
               end else if (phase == term) begin
                  case (state)
                     BEEP_ON: begin
                        if (beep_cnt < BEEPS - 1) begin
                           state    <= BEEP_OFF;
                           phase    <= '0;
                           beep_cnt <= beep_cnt + 32'd1;
                           active_q <= 1'b0;
                           tone_q   <= '0;
                        end else if (burst_cnt + 32'd1 == MAX_BURSTS) begin
                           // Final burst done: give up and flag it.
                           state       <= IDLE;
                           phase       <= '0;
                           beep_cnt    <= '0;
                           burst_cnt   <= '0;
                           snooze_cnt  <= '0;
                           level       <= '0;
                           active_q    <= 1'b0;
                           tone_q      <= '0;
                           busy_q      <= 1'b0;
                           timed_out_q <= 1'b1;
                        end else begin
                           state     <= PAUSE;
                           phase     <= '0;
                           beep_cnt  <= '0;
                           burst_cnt <= burst_cnt + 32'd1;
                           level     <= (level == 2'd3) ? 2'd3 : level + 2'd1;
                           active_q  <= 1'b0;
                           tone_q    <= '0;
                        end
                     end
                     BEEP_OFF, PAUSE: begin
                        state    <= BEEP_ON;
                        phase    <= '0;
                        active_q <= 1'b1;
                        tone_q   <= tone_of(level);
                     end
                     SNOOZE: begin
                        // Wake up at the quietest tone; snooze budget persists.
                        state      <= BEEP_ON;
                        phase      <= '0;
                        beep_cnt   <= '0;
                        burst_cnt  <= '0;
                        level      <= '0;
                        active_q   <= 1'b1;
                        tone_q     <= TONE0;
                        snoozing_q <= 1'b0;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_beep_sequencer.sv
module tb_alarm_beep_sequencer;

   localparam logic [23:0] T0 = 24'h000001;
   localparam logic [23:0] T1 = 24'h000003;
   localparam logic [23:0] T2 = 24'h000007;
   localparam logic [23:0] T3 = 24'h00000F;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alarm_beep_sequencer_if ifc ();

   alarm_beep_sequencer #(
      .BEEP_ON_CYC (4),
      .BEEP_OFF_CYC(2),
      .BEEPS       (3),
      .PAUSE_CYC   (8),
      .MAX_BURSTS  (5),
      .SNOOZE_CYC  (20),
      .MAX_SNOOZE  (2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc.slave)
   );

   typedef struct {
      int          cyc;
      logic        trig;
      logic        act;
      logic [23:0] tone;
      logic        snz;
      logic        busy;
      logic        to;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;
   int   to_pulses = 0;

   function automatic vec_t mk(int c, logic tr, logic a, logic [23:0] t, logic s, logic b, logic o);
      vec_t v;
      v.cyc = c; v.trig = tr; v.act = a; v.tone = t; v.snz = s; v.busy = b; v.to = o;
      return v;
   endfunction

   task automatic chk(input string nm, input logic a, input logic [23:0] t,
                      input logic s, input logic b, input logic o);
      nvec++;
      if ({ifc.alarm_active, ifc.tone_bus, ifc.snoozing, ifc.busy, ifc.timed_out} !== {a, t, s, b, o}) begin
         nerr++;
         $display("FAIL %s cyc=%0d: got act=%b tone=%h snz=%b busy=%b to=%b, want act=%b tone=%h snz=%b busy=%b to=%b",
                  nm, cyc, ifc.alarm_active, ifc.tone_bus, ifc.snoozing, ifc.busy, ifc.timed_out,
                  a, t, s, b, o);
      end
   endtask

   // Inputs held across one rising edge, outputs sampled 1 time unit after it.
   task automatic step(input logic tr, input logic sn, input logic di);
      ifc.alarm_trigger = tr;
      ifc.snooze        = sn;
      ifc.dismiss       = di;
      @(posedge clk);
      #1;
      ifc.alarm_trigger = 1'b0;
      ifc.snooze        = 1'b0;
      ifc.dismiss       = 1'b0;
      cyc++;
      if (ifc.timed_out === 1'b1) to_pulses++;
   endtask

   task automatic go(input int n);
      while (cyc < n) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      ifc.alarm_trigger = 1'b0;
      ifc.snooze        = 1'b0;
      ifc.dismiss       = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      to_pulses = 0;
      chk("reset", 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int p;
      vec_t v;
      logic tr;

      // Burst pattern, mid-burst retrigger, escalation, saturation and timeout.
      // Bursts start at cycles 1,25,49,73,97: on 4 / off 2 x3 beeps, then pause 8.
      tbl.push_back(mk(  0, 1, 0, 24'h0, 0, 0, 0));
      tbl.push_back(mk(  1, 0, 1, T0,    0, 1, 0));
      tbl.push_back(mk(  4, 0, 1, T0,    0, 1, 0));
      tbl.push_back(mk(  5, 0, 0, 24'h0, 0, 1, 0));
      tbl.push_back(mk(  6, 0, 0, 24'h0, 0, 1, 0));
      tbl.push_back(mk(  7, 0, 1, T0,    0, 1, 0));
      tbl.push_back(mk(  8, 1, 1, T0,    0, 1, 0));
      tbl.push_back(mk( 10, 0, 1, T0,    0, 1, 0));
      tbl.push_back(mk( 11, 0, 0, 24'h0, 0, 1, 0));
      tbl.push_back(mk( 13, 0, 1, T0,    0, 1, 0));
      tbl.push_back(mk( 16, 0, 1, T0,    0, 1, 0));
      tbl.push_back(mk( 17, 0, 0, 24'h0, 0, 1, 0));
      tbl.push_back(mk( 24, 0, 0, 24'h0, 0, 1, 0));
      tbl.push_back(mk( 25, 0, 1, T1,    0, 1, 0));
      tbl.push_back(mk( 49, 0, 1, T2,    0, 1, 0));
      tbl.push_back(mk( 72, 0, 0, 24'h0, 0, 1, 0));
      tbl.push_back(mk( 73, 0, 1, T3,    0, 1, 0));
      tbl.push_back(mk( 97, 1, 1, T3,    0, 1, 0));
      tbl.push_back(mk(101, 0, 0, 24'h0, 0, 1, 0));
      tbl.push_back(mk(112, 0, 1, T3,    0, 1, 0));
      tbl.push_back(mk(113, 0, 0, 24'h0, 0, 0, 1));
      tbl.push_back(mk(114, 0, 0, 24'h0, 0, 0, 0));

      do_reset();
      p = 0;
      while (cyc < 116) begin
         tr = 1'b0;
         while (p < tbl.size() && tbl[p].cyc == cyc) begin
            v = tbl[p];
            chk("pattern", v.act, v.tone, v.snz, v.busy, v.to);
            tr = tr | v.trig;
            p++;
         end
         step(tr, 1'b0, 1'b0);
      end
      nvec++;
      if (to_pulses != 1) begin
         nerr++;
         $display("FAIL timeout_count: got %0d pulses, want 1", to_pulses);
      end

      // Snooze: entry, wake-up at TONE0, budget of two, then ignored.
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      go(26);
      chk("pre_snooze_tone1", 1'b1, T1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("snooze1_entry", 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
      go(46);
      chk("snooze1_last", 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("snooze1_wake", 1'b1, T0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("snooze2_entry", 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
      go(67);
      chk("snooze2_last", 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("snooze2_wake", 1'b1, T0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("snooze3_ignored", 1'b1, T0, 1'b0, 1'b1, 1'b0);
      go(84);
      chk("pause_after_wake", 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);

      // Dismiss beats snooze in the same cycle; restart is fully fresh.
      go(86);
      step(1'b0, 1'b1, 1'b1);
      chk("dismiss_over_snooze", 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("retrigger_level0", 1'b1, T0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("snooze_budget_reset", 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("dismiss_from_snooze", 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a beep.
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      go(2);
      chk("pre_async_reset", 1'b1, T0, 1'b0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      go(12);
      chk("idle_after_reset", 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("trigger_after_reset", 1'b1, T0, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
